// File: rtl/coherence_arbiter.sv
// Bus arbiter between L1 cache ports and the lower-level cache.
// Round-robin among caches; the Lx cache wins outright; owners are held until released.
module coherence_arbiter #(
    parameter int MSG_BITS   = 4,
    parameter int NUM_CACHES = 4,
    parameter int NO_REQ     = 0,
    parameter int TIMEOUT    = 64,
    localparam int BUS_PORTS = NUM_CACHES + 1,
    localparam int MEM_PORT  = NUM_CACHES,
    localparam int IDX_W     = $clog2(BUS_PORTS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_CACHES*MSG_BITS-1:0] cache2mem_msg,
    input  logic                           mem_req,
    input  logic                           txn_done,
    output logic [BUS_PORTS-1:0]           grant,
    output logic [IDX_W-1:0]               grant_idx,
    output logic                           grant_valid,
    output logic                           timeout
);

    localparam int PTR_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(TIMEOUT - 1);
    localparam logic [MSG_BITS-1:0]  IDLE_MSG = MSG_BITS'(NO_REQ);
    localparam logic [IDX_W-1:0]     MEM_IDX  = IDX_W'(MEM_PORT);
    localparam logic [PTR_W-1:0]     LAST_C   = PTR_W'(NUM_CACHES - 1);
    localparam logic [BUS_PORTS-1:0] ONE      = BUS_PORTS'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_n;
    logic [BUS_PORTS-1:0] grant_q, grant_n;
    logic [IDX_W-1:0]     idx_q, idx_n;
    logic [PTR_W-1:0]     rr_ptr, rr_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 to_q, to_n;

    logic [NUM_CACHES-1:0] req;
    logic                  pick_found;
    logic [PTR_W-1:0]      pick;
    logic                  owner_req;
    logic                  natural_rel;
    logic                  hit;
    int                    cand;

    always_comb begin
        for (int j = 0; j < NUM_CACHES; j++) begin
            req[j] = cache2mem_msg[j*MSG_BITS +: MSG_BITS] != IDLE_MSG;
        end
    end

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        cand       = 0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_CACHES) cand = cand - NUM_CACHES;
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick       = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        if (idx_q == MEM_IDX) owner_req = mem_req;
        else                  owner_req = req[idx_q[PTR_W-1:0]];
    end

    assign hit         = cnt == CNT_MAX;
    assign natural_rel = txn_done || !owner_req;

    always_comb begin
        state_n = state;
        grant_n = grant_q;
        idx_n   = idx_q;
        rr_n    = rr_ptr;
        cnt_n   = cnt;
        to_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_req) begin
                    state_n = BUSY;
                    grant_n = ONE << MEM_IDX;
                    idx_n   = MEM_IDX;
                    cnt_n   = '0;
                end else if (pick_found) begin
                    state_n = BUSY;
                    grant_n = ONE << pick;
                    idx_n   = IDX_W'(pick);
                    cnt_n   = '0;
                end
            end
            BUSY: begin
                if (natural_rel || hit) begin
                    state_n = IDLE;
                    grant_n = '0;
                    idx_n   = '0;
                    cnt_n   = '0;
                    to_n    = !natural_rel;
                    if (idx_q != MEM_IDX) begin
                        rr_n = (idx_q[PTR_W-1:0] == LAST_C) ? '0
                             : idx_q[PTR_W-1:0] + 1'b1;
                    end
                end else if (!hit) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            rr_ptr  <= '0;
            cnt     <= '0;
            to_q    <= 1'b0;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            idx_q   <= idx_n;
            rr_ptr  <= rr_n;
            cnt     <= cnt_n;
            to_q    <= to_n;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = |grant_q;
    assign timeout     = to_q;

endmodule

// File: tb/tb_coherence_arbiter.sv
// Directed scoreboard bench for coherence_arbiter.
// Expected outputs are queued with each stimulus step and checked after the edge.
module tb_coherence_arbiter;

    logic        clock;
    logic        reset;
    logic [15:0] c2m;
    logic        mem_req;
    logic        txn_done;
    logic [4:0]  grant;
    logic [2:0]  grant_idx;
    logic        grant_valid;
    logic        timeout;

    int tests;
    int fails;

    typedef struct packed {
        logic [4:0] g;
        logic [2:0] i;
        logic       to;
    } exp_t;

    exp_t sb[$];

    coherence_arbiter #(
        .MSG_BITS(4),
        .NUM_CACHES(4),
        .NO_REQ(0),
        .TIMEOUT(64)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cache2mem_msg(c2m),
        .mem_req(mem_req),
        .txn_done(txn_done),
        .grant(grant),
        .grant_idx(grant_idx),
        .grant_valid(grant_valid),
        .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] mk(input logic [3:0] a0, input logic [3:0] a1,
                                       input logic [3:0] a2, input logic [3:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [15:0] msg, input logic mr,
                        input logic done, input logic rst,
                        input logic [4:0] eg, input logic [2:0] ei, input logic eto);
        exp_t e;
        exp_t n;
        c2m      = msg;
        mem_req  = mr;
        txn_done = done;
        reset    = rst;
        n.g  = eg;
        n.i  = ei;
        n.to = eto;
        sb.push_back(n);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check({tag, "/grant"}, 32'(grant), 32'(e.g));
        check({tag, "/idx"}, 32'(grant_idx), 32'(e.i));
        check({tag, "/valid"}, 32'(grant_valid), 32'(|e.g));
        check({tag, "/timeout"}, 32'(timeout), 32'(e.to));
    endtask

    initial begin
        logic [15:0] none;
        logic [15:0] all;
        tests    = 0;
        fails    = 0;
        none     = 16'h0;
        all      = mk(4'h1, 4'h2, 4'h3, 4'h4);
        reset    = 1'b0;
        c2m      = '0;
        mem_req  = 1'b0;
        txn_done = 1'b0;

        step("rst0", none, 0, 0, 0, 5'b00000, 3'd0, 0);
        step("rst_req", all, 1, 0, 0, 5'b00000, 3'd0, 0);
        step("idle", none, 0, 0, 1, 5'b00000, 3'd0, 0);

        // Single requester, released by txn_done.
        step("c2_grant", mk(0, 0, 5, 0), 0, 0, 1, 5'b00100, 3'd2, 0);
        step("c2_hold", mk(0, 0, 5, 0), 1, 0, 1, 5'b00100, 3'd2, 0);
        step("c2_done", mk(0, 0, 5, 0), 0, 1, 1, 5'b00000, 3'd0, 0);
        step("c2_idle", none, 0, 0, 1, 5'b00000, 3'd0, 0);

        // Round robin from rr_ptr=3 over caches 0,1,3.
        step("rr_3a", mk(1, 1, 0, 1), 0, 0, 1, 5'b01000, 3'd3, 0);
        step("rr_3a_rel", mk(1, 1, 0, 1), 0, 1, 1, 5'b00000, 3'd0, 0);
        step("rr_0", mk(1, 1, 0, 1), 0, 0, 1, 5'b00001, 3'd0, 0);
        step("rr_0_rel", mk(1, 1, 0, 1), 0, 1, 1, 5'b00000, 3'd0, 0);
        step("rr_1", mk(1, 1, 0, 1), 0, 0, 1, 5'b00010, 3'd1, 0);
        step("rr_1_rel", mk(1, 1, 0, 1), 0, 1, 1, 5'b00000, 3'd0, 0);
        step("rr_3b", mk(1, 1, 0, 1), 0, 0, 1, 5'b01000, 3'd3, 0);
        step("rr_3b_rel", mk(1, 1, 0, 1), 0, 1, 1, 5'b00000, 3'd0, 0);
        step("rr_idle", none, 0, 0, 1, 5'b00000, 3'd0, 0);

        // Lx priority over cache 1; rr_ptr is 0 here.
        step("mem_win", mk(0, 7, 0, 0), 1, 0, 1, 5'b10000, 3'd4, 0);
        step("mem_hold", mk(0, 7, 0, 0), 1, 0, 1, 5'b10000, 3'd4, 0);
        step("mem_drop", mk(0, 7, 0, 0), 0, 0, 1, 5'b00000, 3'd0, 0);
        step("c1_after", mk(0, 7, 0, 0), 0, 0, 1, 5'b00010, 3'd1, 0);
        step("c1_msgrel", none, 0, 0, 1, 5'b00000, 3'd0, 0);
        step("rr_2", all, 0, 0, 1, 5'b00100, 3'd2, 0);
        step("rr_2_rel", none, 0, 0, 1, 5'b00000, 3'd0, 0);

        // rr_ptr=3 must survive a Lx transaction.
        step("mem2_win", mk(1, 0, 0, 1), 1, 0, 1, 5'b10000, 3'd4, 0);
        step("mem2_rel", mk(1, 0, 0, 1), 1, 1, 1, 5'b00000, 3'd0, 0);
        step("rr_keep", mk(1, 0, 0, 1), 0, 0, 1, 5'b01000, 3'd3, 0);
        step("rr_keep_rel", none, 0, 0, 1, 5'b00000, 3'd0, 0);

        // Forced release 64 cycles after the grant.
        step("to_grant", mk(1, 0, 0, 0), 0, 0, 1, 5'b00001, 3'd0, 0);
        for (int k = 1; k < 64; k++) begin
            step("to_hold", mk(1, 0, 0, 0), 0, 0, 1, 5'b00001, 3'd0, 0);
        end
        step("to_fire", mk(1, 0, 0, 0), 0, 0, 1, 5'b00000, 3'd0, 1);
        step("to_pulse", none, 0, 0, 1, 5'b00000, 3'd0, 0);
        step("to_rr1", mk(1, 1, 0, 0), 0, 0, 1, 5'b00010, 3'd1, 0);

        // txn_done on the timeout cycle: normal release.
        for (int k = 1; k < 64; k++) begin
            step("tc_hold", mk(1, 1, 0, 0), 0, 0, 1, 5'b00010, 3'd1, 0);
        end
        step("tc_done", mk(1, 1, 0, 0), 0, 1, 1, 5'b00000, 3'd0, 0);
        step("tc_quiet", none, 0, 0, 1, 5'b00000, 3'd0, 0);

        // Reset while cache 2 owns the bus.
        step("rm_grant", mk(0, 0, 9, 0), 0, 0, 1, 5'b00100, 3'd2, 0);
        step("rm_reset", mk(0, 0, 9, 0), 0, 0, 0, 5'b00000, 3'd0, 0);
        step("rm_first", all, 0, 0, 1, 5'b00001, 3'd0, 0);
        step("rm_rel", none, 0, 1, 1, 5'b00000, 3'd0, 0);

        // txn_done in IDLE is ignored.
        step("id_done", none, 0, 1, 1, 5'b00000, 3'd0, 0);
        step("id_quiet", none, 0, 0, 1, 5'b00000, 3'd0, 0);
        step("id_grant", mk(0, 0, 0, 2), 0, 0, 1, 5'b01000, 3'd3, 0);
        step("id_rel", none, 0, 0, 1, 5'b00000, 3'd0, 0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/coherence_arbiter.md
COHERENCE_ARBITER -- requirements
Module: coherence_arbiter

Interface
REQ-001 The block SHALL have parameter MSG_BITS, default 4, giving the width of one coherence message.
REQ-002 The block SHALL have parameter NUM_CACHES, default 4, giving the number of L1 cache ports.
REQ-003 The block SHALL have parameter NO_REQ, default 0, giving the idle message encoding.
REQ-004 The block SHALL have parameter TIMEOUT, default 64, giving the maximum number of cycles a grant may be held.
REQ-005 The block SHALL define derived constants BUS_PORTS = NUM_CACHES+1, MEM_PORT = NUM_CACHES and IDX_W = log2(BUS_PORTS).
REQ-006 clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous reset, active-low; asserted while 0.
REQ-008 cache2mem_msg  input  NUM_CACHES*MSG_BITS  per-cache messages packed flat; cache j occupies bits [j*MSG_BITS +: MSG_BITS].
REQ-009 mem_req  input  1  request from the lower-level (Lx) cache for the bus.
REQ-010 txn_done  input  1  single-cycle pulse from the coherence controller marking the end of the granted transaction.
REQ-011 grant  output  BUS_PORTS  one-hot owner vector; bit MEM_PORT is the Lx cache.
REQ-012 grant_idx  output  IDX_W  binary index of the owner; 0 when no owner.
REQ-013 grant_valid  output  1  high while grant is non-zero.
REQ-014 timeout  output  1  single-cycle pulse on a forced release.

Function
REQ-015 Cache j SHALL be treated as requesting when its message slice is not equal to NO_REQ.
REQ-016 The arbiter SHALL implement two states: IDLE (no owner) and BUSY (owner held).
REQ-017 In IDLE with mem_req=1, the arbiter SHALL grant MEM_PORT at the next edge, taking priority over all caches.
REQ-018 In IDLE with mem_req=0 and at least one cache requesting, the arbiter SHALL grant the first requesting cache at or after rr_ptr, searching in increasing index order modulo NUM_CACHES.
REQ-019 The grant SHALL take effect at the next edge (latency 1 cycle from request to grant), and the state SHALL change to BUSY at that edge.
REQ-020 In IDLE with no requests, all outputs SHALL hold 0.
REQ-021 In BUSY, grant and grant_idx SHALL be held constant regardless of other requests or of mem_req.
REQ-022 In BUSY, an owner SHALL be released when any of the following occurs:
  - txn_done=1;
  - a cache owner's message returns to NO_REQ;
  - a MEM_PORT owner's mem_req falls to 0;
  - the hold counter reaches TIMEOUT-1.
REQ-023 On release, outputs SHALL clear at the next edge and the state SHALL return to IDLE, guaranteeing at least one ungranted cycle between owners.
REQ-024 On release of a cache owner k, rr_ptr SHALL become (k+1) mod NUM_CACHES.
REQ-025 On release of MEM_PORT, rr_ptr SHALL be unchanged.
REQ-026 The hold counter SHALL clear on every grant and increment by 1 each BUSY cycle, saturating at TIMEOUT-1.
REQ-027 A timeout release SHALL pulse timeout=1 for exactly the cycle in which grant clears.
REQ-028 When txn_done and the timeout condition coincide, the release SHALL be treated as normal and timeout SHALL stay 0.
REQ-029 A txn_done pulse received in IDLE SHALL be ignored.
REQ-030 grant SHALL be one-hot or zero in every cycle, and grant_valid SHALL equal the OR-reduction of grant.

Reset
REQ-031 While reset=0 at an edge, the block SHALL force state IDLE, grant=0, grant_idx=0, grant_valid=0, timeout=0, rr_ptr=0 and hold counter=0.
REQ-032 Reset asserted mid-transaction SHALL drop the grant at that edge with no timeout pulse.
REQ-033 The first arbitration after reset deassertion SHALL occur at the next edge.

Verification
REQ-034 After reset, cache2mem msg[2]=nonzero, others NO_REQ -> grant=5'b00100 and grant_idx=2 one cycle later; txn_done pulse -> grant=0 next cycle and rr_ptr=3.
REQ-035 With rr_ptr=3 and caches 0, 1 and 3 requesting continuously -> grants SHALL follow the order 3, 0, 1, 3, with an idle cycle between each owner.
REQ-036 Cache 1 and mem_req asserted in the same IDLE cycle -> grant=5'b10000 and grant_idx=4; after mem_req drops -> cache 1 is granted next with rr_ptr unchanged.
REQ-037 Cache 0 granted and never released, TIMEOUT=64 -> grant clears and timeout pulses exactly 64 cycles after the grant, and rr_ptr=1.
REQ-038 Reset driven low while cache 2 holds the grant -> all outputs are 0 at the next edge, timeout stays 0, and cache 0 wins first if all caches request after reset.
REQ-039 A txn_done pulse in IDLE with no requests -> no grant and no state change.
